ctrl_sequencer: RTL and testbench

- Hardwired control unit sitting directly upstream of the single-bus datapath (main1).
- Replaces per-T-state manual stimulus: steps through fetch (T0-T2), then opcode-specific execute states.
- Drives every datapath control strobe for one complete instruction per pass.
- Consumes IR contents and the CON flip-flop result back from the datapath.

---
 rtl/ctrl_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// Hardwired control sequencer for the single-bus datapath: fetch T0-T2, then opcode execute T3-T7.
// Latency: one state per clk; fetch takes 3 cycles; ld/st take 8, ldi/addi/andi/ori take 6, br takes 7, nop takes 3.
// Backpressure: mem_ready=0 holds T1 (fetch read), ld T6 (read) and st T7 (write) with their strobes held high.
//
// Ports: clk, reset_n (async active-low), IR (opcode IR[31:27]), con_ff (branch condition),
//        mem_ready (memory handshake) -> run plus the datapath, register-select and memory strobes, ALUselect.
// Optional build macro CTRL_HALT_EN: opcode 11011 parks the FSM in HALTED with run=0 until reset.
module ctrl_sequencer #(
    parameter logic [3:0] ALU_ADD = 4'b0001,
    parameter logic [3:0] ALU_AND = 4'b0110,
    parameter logic [3:0] ALU_OR  = 4'b0111,
    parameter logic [3:0] ALU_INC = 4'b1001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] IR,
    input  logic        con_ff,
    input  logic        mem_ready,
    output logic        run,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        ZLowout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        conIn,
    output logic        MDRread,
    output logic        memWrite,
    output logic [3:0]  ALUselect
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10010;
`ifdef CTRL_HALT_EN
    localparam logic [4:0] OP_HALT = 5'b11011;
`endif

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7
`ifdef CTRL_HALT_EN
        , S_HALTED
`endif
    } state_t;

    state_t state, state_nxt;

    logic [4:0] opcode;
    logic       is_ld, is_ldi, is_st, is_andi, is_ori, is_br, is_alu;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign is_ld     = (opcode == OP_LD);
    assign is_ldi    = (opcode == OP_LDI);
    assign is_st     = (opcode == OP_ST);
    assign is_andi   = (opcode == OP_ANDI);
    assign is_ori    = (opcode == OP_ORI);
    assign is_br     = (opcode == OP_BR);
    assign is_alu    = (opcode == OP_ADDI) || is_andi || is_ori;

`ifdef CTRL_HALT_EN
    assign run = (state != S_HALTED);
`else
    assign run = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_T0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_T0: state_nxt = S_T1;
            S_T1: if (mem_ready) state_nxt = S_T2;
            // IR is loaded on the T2 exit edge, so the decision uses the value presented on IR now.
            S_T2: begin
                if (is_ld || is_ldi || is_st || is_alu || is_br) begin
                    state_nxt = S_T3;
`ifdef CTRL_HALT_EN
                end else if (opcode == OP_HALT) begin
                    state_nxt = S_HALTED;
`endif
                end else begin
                    state_nxt = S_T0;
                end
            end
            S_T3: state_nxt = S_T4;
            S_T4: state_nxt = S_T5;
            S_T5: state_nxt = (is_ldi || is_alu) ? S_T0 : S_T6;
            S_T6: begin
                if (is_ld) begin
                    if (mem_ready) state_nxt = S_T7;
                end else if (is_st) begin
                    state_nxt = S_T7;
                end else begin
                    state_nxt = S_T0;
                end
            end
            S_T7: if (mem_ready) state_nxt = S_T0;
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; ZLowout = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; Cout = 1'b0; conIn = 1'b0; MDRread = 1'b0; memWrite = 1'b0;
        ALUselect = 4'b0000;
        // Strobes stay quiet for as long as reset is held, even though state already reads T0.
        if (reset_n) begin
            case (state)
                S_T0: begin
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; ALUselect = ALU_INC;
                end
                S_T1: begin
                    // PC is loaded only on the cycle the read completes, so a stalled fetch loads it once.
                    ZLowout = 1'b1; MDRread = 1'b1; MDRin = 1'b1; PCin = mem_ready;
                end
                S_T2: begin
                    MDRout = 1'b1; IRin = 1'b1;
                end
                S_T3: begin
                    if (is_br) begin
                        Gra = 1'b1; Rout = 1'b1; conIn = 1'b1;
                    end else if (is_alu) begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end else if (is_ld || is_ldi || is_st) begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end
                end
                S_T4: begin
                    if (is_br) begin
                        PCout = 1'b1; Yin = 1'b1;
                    end else begin
                        Cout = 1'b1; Zin = 1'b1;
                        ALUselect = is_andi ? ALU_AND : (is_ori ? ALU_OR : ALU_ADD);
                    end
                end
                S_T5: begin
                    if (is_br) begin
                        Cout = 1'b1; Zin = 1'b1; ALUselect = ALU_ADD;
                    end else if (is_ld || is_st) begin
                        ZLowout = 1'b1; MARin = 1'b1;
                    end else begin
                        ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                end
                S_T6: begin
                    if (is_ld) begin
                        MDRread = 1'b1; MDRin = 1'b1;
                    end else if (is_st) begin
                        Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    end else begin
                        ZLowout = 1'b1; PCin = con_ff;
                    end
                end
                S_T7: begin
                    if (is_ld) begin
                        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end else begin
                        MDRout = 1'b1; memWrite = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] IR;
    logic        con_ff;
    logic        mem_ready;
    logic        run, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, ZLowout;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, conIn, MDRread, memWrite;
    logic [3:0]  ALUselect;

    always #5 clk = ~clk;

    ctrl_sequencer dut (
        .clk(clk), .reset_n(reset_n), .IR(IR), .con_ff(con_ff), .mem_ready(mem_ready),
        .run(run), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .ZLowout(ZLowout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .conIn(conIn), .MDRread(MDRread), .memWrite(memWrite), .ALUselect(ALUselect)
    );

    logic [24:0] obs;
    assign obs = {run, ALUselect, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin,
                  ZLowout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, conIn, MDRread, memWrite};

    localparam logic [24:0] M_MEMWRITE = 25'd1 << 0;
    localparam logic [24:0] M_MDRREAD  = 25'd1 << 1;
    localparam logic [24:0] M_CONIN    = 25'd1 << 2;
    localparam logic [24:0] M_COUT     = 25'd1 << 3;
    localparam logic [24:0] M_BAOUT    = 25'd1 << 4;
    localparam logic [24:0] M_ROUT     = 25'd1 << 5;
    localparam logic [24:0] M_RIN      = 25'd1 << 6;
    localparam logic [24:0] M_GRB      = 25'd1 << 8;
    localparam logic [24:0] M_GRA      = 25'd1 << 9;
    localparam logic [24:0] M_ZLOWOUT  = 25'd1 << 10;
    localparam logic [24:0] M_ZIN      = 25'd1 << 11;
    localparam logic [24:0] M_YIN      = 25'd1 << 12;
    localparam logic [24:0] M_IRIN     = 25'd1 << 13;
    localparam logic [24:0] M_MDROUT   = 25'd1 << 14;
    localparam logic [24:0] M_MDRIN    = 25'd1 << 15;
    localparam logic [24:0] M_MARIN    = 25'd1 << 16;
    localparam logic [24:0] M_INCPC    = 25'd1 << 17;
    localparam logic [24:0] M_PCIN     = 25'd1 << 18;
    localparam logic [24:0] M_PCOUT    = 25'd1 << 19;
    localparam logic [24:0] M_RUN      = 25'd1 << 24;

    localparam logic [24:0] A_INC = 25'h9 << 20;
    localparam logic [24:0] A_ADD = 25'h1 << 20;
    localparam logic [24:0] A_AND = 25'h6 << 20;
    localparam logic [24:0] A_OR  = 25'h7 << 20;

    localparam logic [24:0] E_T0   = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN | A_INC;
    localparam logic [24:0] E_T1W  = M_RUN | M_ZLOWOUT | M_MDRREAD | M_MDRIN;
    localparam logic [24:0] E_T1X  = E_T1W | M_PCIN;
    localparam logic [24:0] E_T2   = M_RUN | M_MDROUT | M_IRIN;
    localparam logic [24:0] E_LD3  = M_RUN | M_GRB | M_BAOUT | M_YIN;
    localparam logic [24:0] E_LD4  = M_RUN | M_COUT | M_ZIN | A_ADD;
    localparam logic [24:0] E_LD5  = M_RUN | M_ZLOWOUT | M_MARIN;
    localparam logic [24:0] E_LD6  = M_RUN | M_MDRREAD | M_MDRIN;
    localparam logic [24:0] E_LD7  = M_RUN | M_MDROUT | M_GRA | M_RIN;
    localparam logic [24:0] E_WB5  = M_RUN | M_ZLOWOUT | M_GRA | M_RIN;
    localparam logic [24:0] E_ST6  = M_RUN | M_GRA | M_ROUT | M_MDRIN;
    localparam logic [24:0] E_ST7  = M_RUN | M_MDROUT | M_MEMWRITE;
    localparam logic [24:0] E_AL3  = M_RUN | M_GRB | M_ROUT | M_YIN;
    localparam logic [24:0] E_AL4B = M_RUN | M_COUT | M_ZIN;
    localparam logic [24:0] E_BR3  = M_RUN | M_GRA | M_ROUT | M_CONIN;
    localparam logic [24:0] E_BR4  = M_RUN | M_PCOUT | M_YIN;
    localparam logic [24:0] E_BR6  = M_RUN | M_ZLOWOUT;

    localparam logic [31:0] I_LD   = 32'h00800055;
    localparam logic [31:0] I_LDI  = 32'h08000000;
    localparam logic [31:0] I_ST   = 32'h1080005A;
    localparam logic [31:0] I_ADDI = 32'h5808001A;
    localparam logic [31:0] I_ANDI = 32'h6108001A;
    localparam logic [31:0] I_ORI  = 32'h6908001A;
    localparam logic [31:0] I_BR   = 32'h91000023;
    localparam logic [31:0] I_NOP  = 32'hF8000000;
    localparam logic [31:0] I_HALT = 32'hD8000000;

    typedef struct {
        logic [31:0] ir;
        logic        mr;
        logic        con;
        logic [24:0] exp;
        logic [47:0] tag;
    } vec_t;

    vec_t        vecs[$];
    logic [24:0] sb[$];
    int          checks = 0;
    int          failures = 0;

    task automatic add(input logic [31:0] ir, input logic mr, input logic con,
                       input logic [24:0] exp, input logic [47:0] tag);
        vec_t v;
        v.ir = ir; v.mr = mr; v.con = con; v.exp = exp; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic fetch(input logic [31:0] ir, input logic con, input int t1_stall);
        add(ir, 1'b1, con, E_T0, "T0");
        for (int i = 0; i < t1_stall; i++) add(ir, 1'b0, con, E_T1W, "T1wait");
        add(ir, 1'b1, con, E_T1X, "T1");
        add(ir, 1'b1, con, E_T2, "T2");
    endtask

    // Expected word enters the scoreboard as stimulus is applied; it is compared when the
    // output is sampled mid-cycle.
    task automatic sample(input logic [24:0] exp, input logic [47:0] tag);
        logic [24:0] e;
        sb.push_back(exp);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, obs, e, $time);
        end
    endtask

    task automatic step(input logic [31:0] ir, input logic mr, input logic con,
                        input logic [24:0] exp, input logic [47:0] tag);
        IR = ir; mem_ready = mr; con_ff = con;
        sample(exp, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; IR = 32'h0; con_ff = 1'b0; mem_ready = 1'b1;

        // Build the vector table.
        fetch(I_LD, 1'b0, 0);
        add(I_LD, 1'b1, 1'b0, E_LD3, "ld3"); add(I_LD, 1'b1, 1'b0, E_LD4, "ld4");
        add(I_LD, 1'b1, 1'b0, E_LD5, "ld5"); add(I_LD, 1'b1, 1'b0, E_LD6, "ld6");
        add(I_LD, 1'b1, 1'b0, E_LD7, "ld7");
        fetch(I_LDI, 1'b0, 0);
        add(I_LDI, 1'b1, 1'b0, E_LD3, "ldi3"); add(I_LDI, 1'b1, 1'b0, E_LD4, "ldi4");
        add(I_LDI, 1'b1, 1'b0, E_WB5, "ldi5");
        fetch(I_ADDI, 1'b0, 2);
        add(I_ADDI, 1'b1, 1'b0, E_AL3, "addi3"); add(I_ADDI, 1'b1, 1'b0, E_AL4B | A_ADD, "addi4");
        add(I_ADDI, 1'b1, 1'b0, E_WB5, "addi5");
        fetch(I_ANDI, 1'b0, 0);
        add(I_ANDI, 1'b1, 1'b0, E_AL3, "andi3"); add(I_ANDI, 1'b1, 1'b0, E_AL4B | A_AND, "andi4");
        add(I_ANDI, 1'b1, 1'b0, E_WB5, "andi5");
        fetch(I_ORI, 1'b0, 0);
        add(I_ORI, 1'b1, 1'b0, E_AL3, "ori3"); add(I_ORI, 1'b1, 1'b0, E_AL4B | A_OR, "ori4");
        add(I_ORI, 1'b1, 1'b0, E_WB5, "ori5");
        fetch(I_ST, 1'b0, 0);
        add(I_ST, 1'b1, 1'b0, E_LD3, "st3"); add(I_ST, 1'b1, 1'b0, E_LD4, "st4");
        add(I_ST, 1'b1, 1'b0, E_LD5, "st5"); add(I_ST, 1'b1, 1'b0, E_ST6, "st6");
        for (int i = 0; i < 4; i++) add(I_ST, 1'b0, 1'b0, E_ST7, "st7wt");
        add(I_ST, 1'b1, 1'b0, E_ST7, "st7");
        fetch(I_BR, 1'b0, 0);
        add(I_BR, 1'b1, 1'b0, E_BR3, "br3"); add(I_BR, 1'b1, 1'b0, E_BR4, "br4");
        add(I_BR, 1'b1, 1'b0, E_LD4, "br5"); add(I_BR, 1'b1, 1'b0, E_BR6, "br6nt");
        fetch(I_BR, 1'b1, 0);
        add(I_BR, 1'b1, 1'b1, E_BR3, "br3"); add(I_BR, 1'b1, 1'b1, E_BR4, "br4");
        add(I_BR, 1'b1, 1'b1, E_LD4, "br5"); add(I_BR, 1'b1, 1'b1, E_BR6 | M_PCIN, "br6tk");
        fetch(I_NOP, 1'b0, 0);
        fetch(I_LD, 1'b0, 0);
        add(I_LD, 1'b1, 1'b0, E_LD3, "ld3"); add(I_LD, 1'b1, 1'b0, E_LD4, "ld4");
        add(I_LD, 1'b1, 1'b0, E_LD5, "ld5");
        add(I_LD, 1'b0, 1'b0, E_LD6, "ld6wt"); add(I_LD, 1'b0, 1'b0, E_LD6, "ld6wt");
        add(I_LD, 1'b1, 1'b0, E_LD6, "ld6"); add(I_LD, 1'b1, 1'b0, E_LD7, "ld7");

        // Reset state: only run is high while reset is held.
        sample(M_RUN, "rst0");
        sample(M_RUN, "rst1");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        foreach (vecs[i]) step(vecs[i].ir, vecs[i].mr, vecs[i].con, vecs[i].exp, vecs[i].tag);

        // Reset asserted in the middle of addi T4, held for three cycles.
        step(I_ADDI, 1'b1, 1'b0, E_T0, "T0");
        step(I_ADDI, 1'b1, 1'b0, E_T1X, "T1");
        step(I_ADDI, 1'b1, 1'b0, E_T2, "T2");
        step(I_ADDI, 1'b1, 1'b0, E_AL3, "addi3");
        sample(E_AL4B | A_ADD, "addi4");
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== M_RUN) begin
            failures++;
            $display("FAIL rst_async got=%h exp=%h", obs, M_RUN);
        end
        for (int i = 0; i < 3; i++) step(I_ADDI, 1'b1, 1'b0, M_RUN, "rstmid");
        reset_n = 1'b1;
        step(I_ADDI, 1'b1, 1'b0, E_T0, "T0post");
        step(I_ADDI, 1'b1, 1'b0, E_T1X, "T1post");
        step(I_ADDI, 1'b1, 1'b0, E_T2, "T2post");
        step(I_ADDI, 1'b1, 1'b0, E_AL3, "addi3");
        step(I_ADDI, 1'b1, 1'b0, E_AL4B | A_ADD, "addi4");
        step(I_ADDI, 1'b1, 1'b0, E_WB5, "addi5");

        // Halt opcode: parks with run low when enabled, otherwise behaves as a nop.
        step(I_HALT, 1'b1, 1'b0, E_T0, "T0");
        step(I_HALT, 1'b1, 1'b0, E_T1X, "T1");
        step(I_HALT, 1'b1, 1'b0, E_T2, "T2");
`ifdef CTRL_HALT_EN
        for (int i = 0; i < 20; i++) step(I_HALT, 1'b1, 1'b0, 25'd0, "halted");
`else
        step(I_HALT, 1'b1, 1'b0, E_T0, "hnopT0");
        step(I_HALT, 1'b1, 1'b0, E_T1X, "hnopT1");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
